// File: rtl/sr_arb_pkg.sv
// sr_arb_pkg
//   Shared types and helpers for the SR-latch ownership-flag arbiter.
//   - state_t : arbiter FSM states
//   - idx_t   : requester index, wide enough for the largest supported N_REQ
//   - PCNT_W  : width of the pulse-length counter
//   - rr_pick : round-robin winner selection
package sr_arb_pkg;

    localparam int PCNT_W    = 4;
    localparam int N_REQ_MAX = 8;

    // Sized for the largest legal requester count so that one package
    // serves every N_REQ setting; request vectors are zero-padded to match.
    typedef logic [$clog2(N_REQ_MAX)-1:0] idx_t;

    typedef enum logic [3:0] {
        INIT     = 4'd0,
        INIT_VFY = 4'd1,
        IDLE     = 4'd2,
        SET_P    = 4'd3,
        SET_VFY  = 4'd4,
        HELD     = 4'd5,
        CLR_P    = 4'd6,
        CLR_VFY  = 4'd7,
        GAP      = 4'd8,
        FAULT    = 4'd9
    } state_t;

    // Returns the first set bit of req at or after ptr, wrapping at n.
    // The scan runs from the farthest offset down to offset 0 so the
    // closest candidate is the last one written and therefore wins.
    // With no request set the result is ptr (callers gate on |req).
    function automatic idx_t rr_pick(input logic [N_REQ_MAX-1:0] req,
                                     input idx_t                 ptr,
                                     input int                   n);
        idx_t win;
        int   j;
        win = ptr;
        for (int k = N_REQ_MAX - 1; k >= 0; k--) begin
            if (k < n) begin
                j = int'(ptr) + k;
                if (j >= n) begin
                    j = j - n;
                end
                if (req[idx_t'(j)]) begin
                    win = idx_t'(j);
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/sr_fb_sync.sv
// sr_fb_sync
//   Two-flop synchroniser for one latch feedback bit that is asynchronous
//   to the arbiter clock. Both flops reset to 0.
//   Ports:
//     i_clk   - arbiter clock
//     i_rst_n - asynchronous active-low reset
//     i_d     - asynchronous input bit
//     o_q     - synchronised output bit
module sr_fb_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/sr_flag_arbiter.sv
// sr_flag_arbiter
//   Round-robin arbiter sharing one external cross-coupled NAND SR latch
//   (the ownership flag) between N_REQ requesters. It drives timed
//   active-low set/clear pulses into the latch, confirms the latch state
//   through synchronised Q/notQ readback and then issues a one-hot grant.
//   The set and clear pins are both derived from the single next state, so
//   they can never be low together.
//
//   Handshake: REQ[i] is a level held until GNT[i] rises; the owner then
//   returns the flag with a single-cycle REL[i] pulse. REL bits from
//   non-owners are ignored, and new requests are only arbitrated in IDLE.
//
//   Ports:
//     CLK, RST_N    - clock, asynchronous active-low reset
//     REQ[N_REQ]    - level requests
//     REL[N_REQ]    - release pulse from the current owner
//     GNT[N_REQ]    - one-hot grant (registered)
//     BUSY          - flag owned or release in progress (registered)
//     SET_N, CLR_N  - latch inputs, active low (registered)
//     Q_FB, NOTQ_FB - latch outputs, asynchronous
//     ERR           - sticky fault flag (registered)
//     DBG_STATE     - current FSM state, for observation only
module sr_flag_arbiter
    import sr_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int PULSE_CYC = 2,
    parameter int VERIFY_TO = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [N_REQ-1:0] REQ,
    input  logic [N_REQ-1:0] REL,
    output logic [N_REQ-1:0] GNT,
    output logic             BUSY,
    output logic             SET_N,
    output logic             CLR_N,
    input  logic             Q_FB,
    input  logic             NOTQ_FB,
    output logic             ERR,
    output logic [3:0]       DBG_STATE
);

    localparam int TCNT_W = $clog2(VERIFY_TO + 1);

    state_t              r_state;
    state_t              w_nxt;
    logic [PCNT_W-1:0]   r_pcnt;
    logic [TCNT_W-1:0]   r_tcnt;
    idx_t                r_win;
    idx_t                r_ptr;
    idx_t                w_pick;
    idx_t                w_ptr_nxt;
    logic [N_REQ_MAX-1:0] w_req_pad;
    logic [N_REQ_MAX-1:0] w_rel_pad;
    logic [N_REQ-1:0]    w_gnt_oh;
    logic                w_qs;
    logic                w_nqs;
    logic                w_valid_set;
    logic                w_valid_clr;
    logic                w_pulse_low;
    logic                w_pulse_last;
    logic                w_vfy_state;
    logic                w_vfy_to;
    logic                w_req_any;
    logic                r_set_n;
    logic                r_clr_n;
    logic [N_REQ-1:0]    r_gnt;
    logic                r_busy;
    logic                r_err;

    sr_fb_sync u_sync_q (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_d     (Q_FB),
        .o_q     (w_qs)
    );

    sr_fb_sync u_sync_nq (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_d     (NOTQ_FB),
        .o_q     (w_nqs)
    );

    assign w_valid_set = w_qs && !w_nqs;
    assign w_valid_clr = !w_qs && w_nqs;
    assign w_req_any   = |REQ;

    always_comb begin
        w_req_pad            = '0;
        w_rel_pad            = '0;
        w_req_pad[N_REQ-1:0] = REQ;
        w_rel_pad[N_REQ-1:0] = REL;
    end

    assign w_pick    = rr_pick(w_req_pad, r_ptr, N_REQ);
    assign w_ptr_nxt = (w_pick == idx_t'(N_REQ - 1)) ? '0 : (w_pick + idx_t'(1));

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            w_gnt_oh[i] = (r_win == idx_t'(i));
        end
    end

    // The pulse counter only advances while the pin is actually low. In
    // INIT the first cycle after reset release still has CLR_N high, so
    // the clear pulse starts one cycle later yet keeps its full length.
    always_comb begin
        w_pulse_low = 1'b0;
        case (r_state)
            INIT, CLR_P: w_pulse_low = !r_clr_n;
            SET_P:       w_pulse_low = !r_set_n;
            default:     w_pulse_low = 1'b0;
        endcase
    end

    assign w_pulse_last = w_pulse_low && (r_pcnt == PCNT_W'(PULSE_CYC - 1));
    assign w_vfy_state  = (r_state == INIT_VFY) || (r_state == SET_VFY) ||
                          (r_state == CLR_VFY);
    assign w_vfy_to     = (r_tcnt == TCNT_W'(VERIFY_TO - 1));

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            INIT: begin
                if (w_pulse_last) w_nxt = INIT_VFY;
            end
            INIT_VFY: begin
                if (w_valid_clr)   w_nxt = IDLE;
                else if (w_vfy_to) w_nxt = FAULT;
            end
            IDLE: begin
                if (w_req_any) w_nxt = SET_P;
            end
            SET_P: begin
                if (w_pulse_last) w_nxt = SET_VFY;
            end
            SET_VFY: begin
                if (w_valid_set)   w_nxt = HELD;
                else if (w_vfy_to) w_nxt = FAULT;
            end
            HELD: begin
                // A lost flag outranks a release arriving in the same cycle.
                if (!w_qs)                 w_nxt = FAULT;
                else if (w_rel_pad[r_win]) w_nxt = CLR_P;
            end
            CLR_P: begin
                if (w_pulse_last) w_nxt = CLR_VFY;
            end
            CLR_VFY: begin
                if (w_valid_clr)   w_nxt = GAP;
                else if (w_vfy_to) w_nxt = FAULT;
            end
            GAP:     w_nxt = IDLE;
            FAULT:   w_nxt = FAULT;
            default: w_nxt = FAULT;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= INIT;
            r_pcnt  <= '0;
            r_tcnt  <= '0;
        end else begin
            r_state <= w_nxt;
            if (w_nxt != r_state) begin
                r_pcnt <= '0;
                r_tcnt <= '0;
            end else begin
                if (w_pulse_low && !w_pulse_last) r_pcnt <= r_pcnt + PCNT_W'(1);
                if (w_vfy_state)                  r_tcnt <= r_tcnt + TCNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_win <= '0;
            r_ptr <= '0;
        end else if (r_state == IDLE && w_req_any) begin
            r_win <= w_pick;
            r_ptr <= w_ptr_nxt;
        end
    end

    // Outputs are registered from the next state so each pin changes on
    // the same edge as the state that owns it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_set_n <= 1'b1;
            r_clr_n <= 1'b1;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_set_n <= (w_nxt != SET_P);
            r_clr_n <= !((w_nxt == INIT) || (w_nxt == CLR_P));
            r_gnt   <= (w_nxt == HELD) ? w_gnt_oh : '0;
            r_busy  <= (w_nxt == HELD) || (w_nxt == CLR_P) || (w_nxt == CLR_VFY);
            r_err   <= (w_nxt == FAULT);
        end
    end

    assign SET_N     = r_set_n;
    assign CLR_N     = r_clr_n;
    assign GNT       = r_gnt;
    assign BUSY      = r_busy;
    assign ERR       = r_err;
    assign DBG_STATE = r_state;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// tb_sr_flag_arbiter
//   Bench for sr_flag_arbiter with a behavioural NAND SR latch on the
//   feedback path, directed reset/grant/release/fault/async-reset steps
//   and a randomized phase whose grant order comes from a round-robin
//   reference model.
module tb_sr_flag_arbiter;
    import sr_arb_pkg::*;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] rel = '0;
    logic [N-1:0] gnt;
    logic         busy;
    logic         set_n;
    logic         clr_n;
    logic         q_fb;
    logic         notq_fb;
    logic         err;
    logic [3:0]   dbg_state;

    logic         lat_q  = 1'b1;
    logic         lat_nq = 1'b0;
    logic         stuck  = 1'b0;

    int n_checks  = 0;
    int n_errs    = 0;
    int inv_both  = 0;
    int inv_gnt   = 0;
    int m_last    = N - 1;

    sr_flag_arbiter #(
        .N_REQ     (N),
        .PULSE_CYC (2),
        .VERIFY_TO (8)
    ) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .REQ       (req),
        .REL       (rel),
        .GNT       (gnt),
        .BUSY      (busy),
        .SET_N     (set_n),
        .CLR_N     (clr_n),
        .Q_FB      (q_fb),
        .NOTQ_FB   (notq_fb),
        .ERR       (err),
        .DBG_STATE (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    // behavioural cross-coupled NAND latch, optionally stuck at Q=0
    always @(set_n or clr_n) begin
        if (!set_n) begin
            lat_q  = 1'b1;
            lat_nq = 1'b0;
        end else if (!clr_n) begin
            lat_q  = 1'b0;
            lat_nq = 1'b1;
        end
    end
    assign q_fb    = stuck ? 1'b0 : lat_q;
    assign notq_fb = lat_nq;

    // invariant monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (set_n === 1'b0 && clr_n === 1'b0) inv_both++;
        if ($countones(gnt) > 1) inv_gnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errs);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] onehot(input int w);
        logic [N-1:0] one;
        one = 1;
        return one << w;
    endfunction

    // Round-robin rule: first requester after the last granted index.
    function automatic int model_pick(input logic [N-1:0] r, input int last);
        for (int off = 1; off <= N; off++) begin
            int i;
            i = (last + off) % N;
            if ((r & onehot(i)) != 0) return i;
        end
        return 0;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        rel   = '0;
        tick();
        chk("rst_set_n", 32'(set_n), 1);
        chk("rst_clr_n", 32'(clr_n), 1);
        chk("rst_gnt",   32'(gnt),   0);
        chk("rst_busy",  32'(busy),  0);
        chk("rst_err",   32'(err),   0);
        chk("rst_state", 32'(dbg_state), 32'(INIT));
        tick();
        rst_n = 1'b1;
        tick();
        chk("init1_clr_n", 32'(clr_n), 0);
        chk("init1_set_n", 32'(set_n), 1);
        tick();
        chk("init2_clr_n", 32'(clr_n), 0);
        tick();
        chk("init3_clr_n", 32'(clr_n), 1);
        chk("init3_set_n", 32'(set_n), 1);
        tick();
        chk("init_idle", 32'(dbg_state), 32'(IDLE));
        chk("init_err",  32'(err), 0);
        m_last = N - 1;
    endtask

    // Call with the DUT in IDLE and req already driven.
    task automatic expect_grant(input int w, input bit keep_req, input bit drop_early);
        logic [N-1:0] oh;
        oh = onehot(w);
        tick();
        chk("setp1_set_n", 32'(set_n), 0);
        chk("setp1_clr_n", 32'(clr_n), 1);
        chk("setp1_gnt",   32'(gnt),   0);
        if (drop_early) req = req & ~oh;
        tick();
        chk("setp2_set_n", 32'(set_n), 0);
        tick();
        chk("setvfy_set_n", 32'(set_n), 1);
        chk("setvfy_gnt",   32'(gnt),   0);
        chk("setvfy_busy",  32'(busy),  0);
        tick();
        chk("grant_gnt",  32'(gnt),  32'(oh));
        chk("grant_busy", 32'(busy), 1);
        if (!keep_req) req = req & ~oh;
        m_last = w;
    endtask

    task automatic do_release(input int w);
        rel = onehot(w);
        tick();
        rel = '0;
        chk("rel_gnt",   32'(gnt),   0);
        chk("rel_busy",  32'(busy),  1);
        chk("rel_clr_n", 32'(clr_n), 0);
        tick();
        chk("clrp2_clr_n", 32'(clr_n), 0);
        chk("clrp2_set_n", 32'(set_n), 1);
        tick();
        chk("clrvfy_clr_n", 32'(clr_n), 1);
        chk("clrvfy_busy",  32'(busy),  1);
        tick();
        chk("gap_busy", 32'(busy), 0);
        chk("gap_gnt",  32'(gnt),  0);
        tick();
        chk("rel_idle", 32'(dbg_state), 32'(IDLE));
    endtask

    initial begin
        int ord[5];
        int w;
        int hold;
        ord = '{0, 1, 2, 3, 0};

        // reset and INIT clear sequence
        do_reset();

        // single requester grant and release
        req = 4'b0001;
        expect_grant(0, 1'b0, 1'b0);
        repeat (2) begin
            tick();
            chk("single_hold_gnt", 32'(gnt), 32'(4'b0001));
        end
        do_release(0);
        tick();
        chk("single_no_req_set_n", 32'(set_n), 1);
        chk("single_no_req_idle",  32'(dbg_state), 32'(IDLE));

        // all four held: round-robin order, non-owner release ignored
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            expect_grant(ord[k], 1'b1, 1'b0);
            if (ord[k] == 2) begin
                rel = 4'b0001;
                tick();
                rel = '0;
                chk("nonowner_rel_gnt",  32'(gnt),  32'(4'b0100));
                chk("nonowner_rel_busy", 32'(busy), 1);
                repeat (3) begin
                    tick();
                    chk("rr_hold_gnt", 32'(gnt), 32'(onehot(ord[k])));
                end
            end else begin
                repeat (4) begin
                    tick();
                    chk("rr_hold_gnt", 32'(gnt), 32'(onehot(ord[k])));
                end
            end
            if (k == 4) req = '0;
            do_release(ord[k]);
        end

        // stuck latch: verify timeout leads to a sticky fault
        stuck = 1'b1;
        req   = 4'b0010;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1)  chk("stuck_set_n_low", 32'(set_n), 0);
            if (k == 10) chk("stuck_err_before", 32'(err), 0);
        end
        tick();
        chk("fault_err",   32'(err),   1);
        chk("fault_set_n", 32'(set_n), 1);
        chk("fault_clr_n", 32'(clr_n), 1);
        chk("fault_gnt",   32'(gnt),   0);
        chk("fault_busy",  32'(busy),  0);
        repeat (3) tick();
        chk("fault_sticky", 32'(err), 1);
        req   = '0;
        stuck = 1'b0;
        do_reset();

        // reset asserted in the middle of a set pulse
        req = 4'b0100;
        tick();
        chk("midset_set_n", 32'(set_n), 0);
        rst_n = 1'b0;
        #1;
        chk("async_set_n", 32'(set_n), 1);
        chk("async_state", 32'(dbg_state), 32'(INIT));
        req = '0;
        do_reset();

        // randomized requests and non-owner releases against the model
        for (int r = 0; r < 24; r++) begin
            if (req == '0) req = N'($urandom_range(1, (1 << N) - 1));
            w = model_pick(req, m_last);
            expect_grant(w, 1'b0, 1'($urandom_range(0, 1)));
            hold = $urandom_range(1, 5);
            for (int h = 0; h < hold; h++) begin
                rel = N'($urandom_range(0, (1 << N) - 1)) & ~onehot(w);
                if ($urandom_range(0, 2) == 0) req = req | N'($urandom_range(0, (1 << N) - 1));
                tick();
                rel = '0;
                chk("rand_hold_gnt",  32'(gnt),  32'(onehot(w)));
                chk("rand_hold_busy", 32'(busy), 1);
            end
            do_release(w);
        end

        chk("inv_both_low", 32'(inv_both), 0);
        chk("inv_gnt_onehot", 32'(inv_gnt), 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
